multi_hart_harness: RTL and testbench

//  Parametrised simulation harness controller for 1..N RV32I harts under test. Sequences hart reset

---
 rtl/harness_pkg.sv | 14 +
 rtl/hart_monitor.sv | 69 ++++++
 rtl/multi_hart_harness.sv | 133 +++++++++++++
 tb/tb_multi_hart_harness.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
// Shared state type and constants for the multi-hart test harness.
package harness_pkg;

   typedef enum logic [1:0] {
      RESET,
      RUN,
      DONE,
      TIMEOUT
   } harness_state_e;

   localparam int unsigned TOHOST_PASS         = 1;
   localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0FFC;

endpackage

// File: rtl/hart_monitor.sv
// Per-hart tohost snoop: first-report detection and pass/fail flag.
// With HARNESS_RETIRE_CNT_EN defined, also a saturating per-hart retire counter.
module hart_monitor
   import harness_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
`ifdef HARNESS_RETIRE_CNT_EN
   parameter int unsigned           CNT_WIDTH   = 32,
`endif
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(DEFAULT_TOHOST_ADDR)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  run_i,
   input  logic                  st_valid_i,
   input  logic [ADDR_WIDTH-1:0] st_addr_i,
   input  logic [DATA_WIDTH-1:0] st_data_i,
`ifdef HARNESS_RETIRE_CNT_EN
   input  logic                  retire_i,
   output logic [CNT_WIDTH-1:0]  retire_cnt_o,
`endif
   output logic                  report_o,
   output logic                  new_fail_o,
   output logic                  finished_o,
   output logic                  fail_o
);

   logic finished_q, finished_d;
   logic fail_q, fail_d;

   always_comb begin
      report_o   = run_i && st_valid_i && (st_addr_i == TOHOST_ADDR) && !finished_q;
      new_fail_o = report_o && (st_data_i != DATA_WIDTH'(TOHOST_PASS));
      finished_d = finished_q | report_o;
      fail_d     = fail_q | new_fail_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         finished_q <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         finished_q <= finished_d;
         fail_q     <= fail_d;
      end
   end

   assign finished_o = finished_q;
   assign fail_o     = fail_q;

`ifdef HARNESS_RETIRE_CNT_EN
   logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (run_i && retire_i && !finished_q && !(&retire_cnt_q))
         retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) retire_cnt_q <= '0;
      else       retire_cnt_q <= retire_cnt_d;
   end

   assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: rtl/multi_hart_harness.sv
// Harness controller: hart reset sequencing, tohost snooping, cycle count and verdict.
// Optional feature macro: HARNESS_RETIRE_CNT_EN (adds retire / retire_cnt ports).
module multi_hart_harness
   import harness_pkg::*;
#(
   parameter int unsigned           NUM_HARTS      = 1,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           CNT_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = ADDR_WIDTH'(DEFAULT_TOHOST_ADDR),
   parameter int unsigned           RESET_CYCLES   = 4,
   parameter int unsigned           TIMEOUT_CYCLES = 100000
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [NUM_HARTS-1:0]             hart_rst_n,
   input  logic [NUM_HARTS-1:0]             st_valid,
   input  logic [NUM_HARTS*ADDR_WIDTH-1:0]  st_addr,
   input  logic [NUM_HARTS*DATA_WIDTH-1:0]  st_data,
`ifdef HARNESS_RETIRE_CNT_EN
   input  logic [NUM_HARTS-1:0]             retire,
   output logic [NUM_HARTS*CNT_WIDTH-1:0]   retire_cnt,
`endif
   output logic                             done,
   output logic                             pass,
   output logic                             timeout,
   output logic [NUM_HARTS-1:0]             fail_mask,
   output logic [DATA_WIDTH-1:0]            fail_code,
   output logic [CNT_WIDTH-1:0]             cycle_cnt
);

   localparam int unsigned          RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RC_W-1:0]      RC_LOAD = RC_W'(RESET_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);

   harness_state_e        state_q, state_d;
   logic [RC_W-1:0]       rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [NUM_HARTS-1:0]  hart_rst_n_q, hart_rst_n_d;
   logic [DATA_WIDTH-1:0] fail_code_q, fail_code_d;

   logic                  run;
   logic [NUM_HARTS-1:0]  report, new_fail, finished, fail;
   logic [DATA_WIDTH-1:0] code_of [NUM_HARTS];
   logic                  found;

   assign run = (state_q == RUN);

   for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
      hart_monitor #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .DATA_WIDTH  (DATA_WIDTH),
`ifdef HARNESS_RETIRE_CNT_EN
         .CNT_WIDTH   (CNT_WIDTH),
`endif
         .TOHOST_ADDR (TOHOST_ADDR)
      ) u_mon (
         .clk_i        (clk),
         .rst_i        (rst),
         .run_i        (run),
         .st_valid_i   (st_valid[g]),
         .st_addr_i    (st_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .st_data_i    (st_data[g*DATA_WIDTH +: DATA_WIDTH]),
`ifdef HARNESS_RETIRE_CNT_EN
         .retire_i     (retire[g]),
         .retire_cnt_o (retire_cnt[g*CNT_WIDTH +: CNT_WIDTH]),
`endif
         .report_o     (report[g]),
         .new_fail_o   (new_fail[g]),
         .finished_o   (finished[g]),
         .fail_o       (fail[g])
      );
      assign code_of[g] = st_data[g*DATA_WIDTH +: DATA_WIDTH] >> 1;
   end

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      unique case (state_q)
         RESET: begin
            if (rst_cnt_q == '0) state_d = RUN;
            else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
         end
         RUN: begin
            if (!(&cycle_cnt_q)) cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
            // same-cycle reports count toward completion, and completion beats timeout
            if (&(finished | report))                   state_d = DONE;
            else if (TO_EN && (cycle_cnt_q == TO_LAST)) state_d = TIMEOUT;
         end
         default: ;
      endcase
      hart_rst_n_d = (state_d == RUN) ? ~(finished | report) : '0;
   end

   // Lowest failing index overall; only a newly failing hart can displace the code.
   always_comb begin
      fail_code_d = fail_code_q;
      found       = 1'b0;
      for (int unsigned i = 0; i < NUM_HARTS; i++) begin
         if (!found && (fail[i] || new_fail[i])) begin
            found = 1'b1;
            if (new_fail[i]) fail_code_d = code_of[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RESET;
         rst_cnt_q    <= RC_LOAD;
         cycle_cnt_q  <= '0;
         hart_rst_n_q <= '0;
         fail_code_q  <= '0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         cycle_cnt_q  <= cycle_cnt_d;
         hart_rst_n_q <= hart_rst_n_d;
         fail_code_q  <= fail_code_d;
      end
   end

   assign hart_rst_n = hart_rst_n_q;
   assign done       = (state_q == DONE) || (state_q == TIMEOUT);
   assign pass       = (state_q == DONE) && !(|fail);
   assign timeout    = (state_q == TIMEOUT);
   assign fail_mask  = fail;
   assign fail_code  = fail_code_q;
   assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_multi_hart_harness.sv
// Randomised bench for multi_hart_harness: a 1-hart and a 4-hart instance against a schedule-level model.
module tb_multi_hart_harness;

   localparam logic [31:0] TOHOST = 32'h0000_0FFC;
   localparam int RC_A = 4;
   localparam int TO_A = 100;
   localparam int RC_B = 3;
   localparam int TO_B = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, sel_b;
   logic [3:0]  vld;
   logic [31:0] adr [4];
   logic [31:0] dat [4];

   logic        hrn_a, done_a, pass_a, to_a, fm_a;
   logic [31:0] fc_a, cc_a;
   logic [3:0]  hrn_b, fm_b;
   logic        done_b, pass_b, to_b;
   logic [31:0] fc_b, cc_b;
`ifdef HARNESS_RETIRE_CNT_EN
   logic [31:0]  rcnt_a;
   logic [127:0] rcnt_b;
`endif

   multi_hart_harness #(.NUM_HARTS(1), .RESET_CYCLES(RC_A), .TIMEOUT_CYCLES(TO_A)) u_dut_a (
      .clk        (clk),
      .rst        (rst_a),
      .hart_rst_n (hrn_a),
      .st_valid   (vld[0] & ~sel_b),
      .st_addr    (adr[0]),
      .st_data    (dat[0]),
`ifdef HARNESS_RETIRE_CNT_EN
      .retire     (1'b0),
      .retire_cnt (rcnt_a),
`endif
      .done       (done_a),
      .pass       (pass_a),
      .timeout    (to_a),
      .fail_mask  (fm_a),
      .fail_code  (fc_a),
      .cycle_cnt  (cc_a)
   );

   multi_hart_harness #(.NUM_HARTS(4), .RESET_CYCLES(RC_B), .TIMEOUT_CYCLES(TO_B)) u_dut_b (
      .clk        (clk),
      .rst        (rst_b),
      .hart_rst_n (hrn_b),
      .st_valid   (vld & {4{sel_b}}),
      .st_addr    ({adr[3], adr[2], adr[1], adr[0]}),
      .st_data    ({dat[3], dat[2], dat[1], dat[0]}),
`ifdef HARNESS_RETIRE_CNT_EN
      .retire     (4'b0000),
      .retire_cnt (rcnt_b),
`endif
      .done       (done_b),
      .pass       (pass_b),
      .timeout    (to_b),
      .fail_mask  (fm_b),
      .fail_code  (fc_b),
      .cycle_cnt  (cc_b)
   );

   logic [3:0]  o_hrn, o_fm;
   logic        o_done, o_pass, o_to;
   logic [31:0] o_fc, o_cc;

   always_comb begin
      if (sel_b) begin
         o_hrn = hrn_b;  o_fm = fm_b;  o_done = done_b; o_pass = pass_b;
         o_to  = to_b;   o_fc = fc_b;  o_cc   = cc_b;
      end else begin
         o_hrn = {3'b000, hrn_a}; o_fm = {3'b000, fm_a}; o_done = done_a; o_pass = pass_a;
         o_to  = to_a;            o_fc = fc_a;           o_cc   = cc_a;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Schedule: hart i writes vv[i] to tohost in RUN cycle tt[i] (-1 = never).
   int          nh, to_cyc, rc;
   int          tt [4];
   logic [31:0] vv [4];

   function automatic bit reported(int i, int k);
      return (tt[i] >= 0) && (tt[i] < k);
   endfunction

   function automatic logic [3:0] mdl_mask(int k);
      logic [3:0] m = '0;
      for (int i = 0; i < nh; i++)
         if (reported(i, k) && vv[i] != 32'd1) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] mdl_code(int k);
      logic [31:0] c = '0;
      for (int i = nh - 1; i >= 0; i--)
         if (reported(i, k) && vv[i] != 32'd1) c = vv[i] >> 1;
      return c;
   endfunction

   function automatic logic [3:0] mdl_hrn(int k);
      logic [3:0] h = '0;
      for (int i = 0; i < nh; i++) h[i] = !reported(i, k);
      return h;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hrn"},  32'(o_hrn),  32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_pass"}, 32'(o_pass), 32'd0);
      chk({tag, "_to"},   32'(o_to),   32'd0);
      chk({tag, "_fm"},   32'(o_fm),   32'd0);
      chk({tag, "_fc"},   o_fc,        32'd0);
      chk({tag, "_cc"},   o_cc,        32'd0);
   endtask

   task automatic drive_run(input int k, input bit noise);
      for (int i = 0; i < 4; i++) begin
         vld[i] = 1'b0;
         adr[i] = $urandom;
         dat[i] = $urandom;
      end
      for (int i = 0; i < nh; i++) begin
         if (k == tt[i]) begin
            vld[i] = 1'b1; adr[i] = TOHOST; dat[i] = vv[i];
         end else if (tt[i] >= 0 && k > tt[i] && $urandom_range(0, 2) == 0) begin
            vld[i] = 1'b1; adr[i] = TOHOST;
         end else if (noise && $urandom_range(0, 2) == 0) begin
            vld[i] = 1'b1;
            adr[i] = TOHOST ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) dat[i] = 32'd1;
         end else if ($urandom_range(0, 1) == 0) begin
            adr[i] = TOHOST;
         end
      end
   endtask

   task automatic run_case(input bit b, input int abort_at, input bit noise);
      bit          all_rep = 1'b1;
      int          tmax = -1;
      bit          is_done;
      int          e_cyc;
      logic [3:0]  nmask;
      sel_b  = b;
      nh     = b ? 4 : 1;
      to_cyc = b ? TO_B : TO_A;
      rc     = b ? RC_B : RC_A;
      nmask  = 4'((1 << nh) - 1);
      for (int i = 0; i < nh; i++) begin
         if (tt[i] < 0) all_rep = 1'b0;
         else if (tt[i] > tmax) tmax = tt[i];
      end
      is_done = all_rep && (tmax <= to_cyc - 1);
      e_cyc   = is_done ? tmax : to_cyc - 1;

      rst_a = 1'b1; rst_b = 1'b1; vld = '0;
      @(negedge clk);
      chk_reset_vals("reset");
      if (b) rst_b = 1'b0; else rst_a = 1'b0;
      for (int j = 1; j <= rc; j++) begin
         @(negedge clk);
         chk("rstseq_hrn", 32'(o_hrn), (j == rc) ? 32'(nmask) : 32'd0);
      end

      for (int k = 0; k <= e_cyc; k++) begin
         if (k > 0) @(negedge clk);
         if (k == abort_at) begin
            #2 rst_a = 1'b1; rst_b = 1'b1;
            #1 chk_reset_vals("abort");
            vld = '0;
            return;
         end
         chk("run_cc",   o_cc,            32'(k));
         chk("run_done", 32'(o_done),     32'd0);
         chk("run_hrn",  32'(o_hrn),      32'(mdl_hrn(k)));
         chk("run_fm",   32'(o_fm),       32'(mdl_mask(k)));
         chk("run_fc",   o_fc,            mdl_code(k));
         drive_run(k, noise);
      end

      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         chk("end_done", 32'(o_done), 32'd1);
         chk("end_to",   32'(o_to),   32'(!is_done));
         chk("end_pass", 32'(o_pass), 32'(is_done && mdl_mask(e_cyc + 1) == 4'd0));
         chk("end_cc",   o_cc,        32'(e_cyc + 1));
         chk("end_fm",   32'(o_fm),   32'(mdl_mask(e_cyc + 1)));
         chk("end_fc",   o_fc,        mdl_code(e_cyc + 1));
         chk("end_hrn",  32'(o_hrn),  32'd0);
         for (int i = 0; i < nh; i++) begin
            vld[i] = 1'($urandom_range(0, 1));
            adr[i] = TOHOST;
            dat[i] = $urandom;
         end
      end
      vld = '0;
   endtask

   task automatic set4(input int t0, t1, t2, t3, input logic [31:0] v0, v1, v2, v3);
      tt[0] = t0; tt[1] = t1; tt[2] = t2; tt[3] = t3;
      vv[0] = v0; vv[1] = v1; vv[2] = v2; vv[3] = v3;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0; vld = '0;
      for (int i = 0; i < 4; i++) begin adr[i] = '0; dat[i] = '0; end

      // single hart: pass at cycle 50, timeout, report on the timeout cycle, failure code
      set4(50, -1, -1, -1, 1, 0, 0, 0);  run_case(1'b0, -1, 1'b1);
      set4(-1, -1, -1, -1, 0, 0, 0, 0);  run_case(1'b0, -1, 1'b1);
      set4(99, -1, -1, -1, 1, 0, 0, 0);  run_case(1'b0, -1, 1'b1);
      set4(10, -1, -1, -1, 6, 0, 0, 0);  run_case(1'b0, -1, 1'b0);

      // four harts: mixed verdicts, same-cycle reports, partial timeout, coincident finish
      set4(12, 25, 8, 30, 1, 5, 7, 1);   run_case(1'b1, -1, 1'b1);
      set4(15, 15, 15, 15, 1, 9, 4, 1);  run_case(1'b1, -1, 1'b1);
      set4(10, -1, 20, -1, 2, 1, 1, 1);  run_case(1'b1, -1, 1'b1);
      set4(59, 3, 40, 59, 1, 1, 1, 1);   run_case(1'b1, -1, 1'b1);
      set4(5, -1, -1, -1, 3, 1, 1, 1);   run_case(1'b1, 20, 1'b1);
      set4(4, 9, 2, 7, 1, 1, 1, 1);      run_case(1'b1, -1, 1'b0);

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 4; i++) begin
            tt[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 70));
            vv[i] = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
         end
         run_case(1'b1, -1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
